maxpool_ctrl: RTL and testbench



---
 rtl/maxpool_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_maxpool_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_ctrl.sv
// rtl/maxpool_ctrl.sv - 2x2 stride-2 max pooling sequencer over a D x H x W map
//
// Walks every 2x2 window (column fastest, then row, then channel), issues
// its four reads one per cycle, folds them through a single signed compare
// into an accumulator, and writes one maximum per window. 5 cycles/window.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           begin a full pass (sampled only when idle)
//   busy, done      pass in progress / one-cycle end-of-pass pulse
//   rd_en, rd_addr  input buffer read strobe and address
//   rd_data         input buffer data, valid the cycle after rd_en
//   wr_en, wr_addr  output buffer write strobe and address
//   wr_data         pooled maximum
module maxpool_ctrl #(
  parameter int DATA_BITS     = 32,
  parameter int D             = 1,
  parameter int W             = 46,
  parameter int H             = 46,
  parameter int IN_ADDR_BITS  = 16,
  parameter int OUT_ADDR_BITS = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_en,
  output logic [IN_ADDR_BITS-1:0]  rd_addr,
  input  logic [DATA_BITS-1:0]     rd_data,
  output logic                     wr_en,
  output logic [OUT_ADDR_BITS-1:0] wr_addr,
  output logic [DATA_BITS-1:0]     wr_data
);

  localparam int CH_W  = (D > 1) ? $clog2(D) : 1;
  localparam int ROW_W = $clog2(H);
  localparam int COL_W = $clog2(W);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_LAST, S_FIN} state_t;

  state_t                   state_q, state_d;
  logic [1:0]               k_q, k_d;
  logic [CH_W-1:0]          ch_q, ch_d;
  logic [ROW_W-1:0]         r_q, r_d;
  logic [COL_W-1:0]         c_q, c_d;
  logic [DATA_BITS-1:0]     acc_q, acc_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     rd_en_q, rd_en_d;
  logic [IN_ADDR_BITS-1:0]  rd_addr_q, rd_addr_d;
  logic                     wr_en_q, wr_en_d;
  logic [OUT_ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_BITS-1:0]     wr_data_q, wr_data_d;

  logic                     last_col, last_row, last_ch, rd_gt;
  logic [CH_W-1:0]          nxt_ch;
  logic [ROW_W-1:0]         nxt_r;
  logic [COL_W-1:0]         nxt_c;
  logic [DATA_BITS-1:0]     result;

  function automatic logic [IN_ADDR_BITS-1:0] in_addr(input logic [31:0] ch,
      input logic [31:0] r, input logic [31:0] c, input logic [1:0] k);
    logic [31:0] a;
    a = ch * 32'(H * W) + (r + {31'd0, k[1]}) * 32'(W) + c + {31'd0, k[0]};
    return a[IN_ADDR_BITS-1:0];
  endfunction

  function automatic logic [OUT_ADDR_BITS-1:0] out_addr(input logic [31:0] ch,
      input logic [31:0] r, input logic [31:0] c);
    logic [31:0] a;
    a = ch * 32'((H / 2) * (W / 2)) + (r >> 1) * 32'(W / 2) + (c >> 1);
    return a[OUT_ADDR_BITS-1:0];
  endfunction

  assign last_col = (c_q == COL_W'(W - 2));
  assign last_row = (r_q == ROW_W'(H - 2));
  assign last_ch  = (ch_q == CH_W'(D - 1));
  assign rd_gt    = $signed(rd_data) > $signed(acc_q);
  assign result   = rd_gt ? rd_data : acc_q;

  // Window counters for the window after the current one.
  always_comb begin
    nxt_c  = c_q + COL_W'(2);
    nxt_r  = r_q;
    nxt_ch = ch_q;
    if (last_col) begin
      nxt_c = '0;
      nxt_r = r_q + ROW_W'(2);
      if (last_row) begin
        nxt_r  = '0;
        nxt_ch = ch_q + CH_W'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    ch_d      = ch_q;
    r_d       = r_q;
    c_d       = c_q;
    acc_d     = acc_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_ISSUE;
          k_d       = 2'd0;
          ch_d      = '0;
          r_d       = '0;
          c_d       = '0;
          busy_d    = 1'b1;
          rd_en_d   = 1'b1;
          rd_addr_d = in_addr(32'd0, 32'd0, 32'd0, 2'd0);
        end
      end
      S_ISSUE: begin
        // rd_data carries the pixel issued for k-1; nothing is valid at k=0.
        if (k_q == 2'd1) begin
          acc_d = rd_data;
        end else if (k_q != 2'd0 && rd_gt) begin
          acc_d = rd_data;
        end
        if (k_q == 2'd3) begin
          state_d = S_LAST;
        end else begin
          k_d       = k_q + 2'd1;
          rd_en_d   = 1'b1;
          rd_addr_d = in_addr(32'(ch_q), 32'(r_q), 32'(c_q), k_q + 2'd1);
        end
      end
      S_LAST: begin
        acc_d     = result;
        wr_en_d   = 1'b1;
        wr_data_d = result;
        wr_addr_d = out_addr(32'(ch_q), 32'(r_q), 32'(c_q));
        if (last_col && last_row && last_ch) begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end else begin
          // The next window's first read overlaps this window's write.
          state_d   = S_ISSUE;
          k_d       = 2'd0;
          ch_d      = nxt_ch;
          r_d       = nxt_r;
          c_d       = nxt_c;
          rd_en_d   = 1'b1;
          rd_addr_d = in_addr(32'(nxt_ch), 32'(nxt_r), 32'(nxt_c), 2'd0);
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      ch_q      <= '0;
      r_q       <= '0;
      c_q       <= '0;
      acc_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      ch_q      <= ch_d;
      r_q       <= r_d;
      c_q       <= c_d;
      acc_q     <= acc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_maxpool_ctrl.sv
// tb/tb_maxpool_ctrl.sv - self-checking bench for maxpool_ctrl
module tb_maxpool_ctrl;

  localparam int NI   = 4;
  localparam int LOGN = 1200;
  localparam int MEMN = 2116;
  localparam int PD [NI] = '{1, 1, 2, 1};
  localparam int PH [NI] = '{4, 2, 4, 46};
  localparam int PW [NI] = '{4, 2, 4, 46};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start   [NI];
  logic        busy    [NI];
  logic        done    [NI];
  logic        rd_en   [NI];
  logic [15:0] rd_addr [NI];
  logic [31:0] rd_data [NI];
  logic        wr_en   [NI];
  logic [15:0] wr_addr [NI];
  logic [31:0] wr_data [NI];

  logic [31:0] mem   [NI][MEMN];
  int          ecnt = 0;
  int          wcnt [NI];
  int          waddr [NI][LOGN];
  logic [31:0] wdata [NI][LOGN];
  int          wcyc  [NI][LOGN];
  int          done_cnt [NI];
  int          done_cyc [NI];
  int          busy_last [NI];
  int          rd_cnt [NI];
  int          rd_max [NI];
  int          rd_oob [NI];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    maxpool_ctrl #(
      .DATA_BITS(32), .D(PD[g]), .W(PW[g]), .H(PH[g]),
      .IN_ADDR_BITS(16), .OUT_ADDR_BITS(16)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start[g]), .busy(busy[g]), .done(done[g]),
      .rd_en(rd_en[g]), .rd_addr(rd_addr[g]), .rd_data(rd_data[g]),
      .wr_en(wr_en[g]), .wr_addr(wr_addr[g]), .wr_data(wr_data[g])
    );
  end

  always @(posedge clk) ecnt++;

  // Synchronous-read input buffers
  always @(posedge clk) begin
    for (int g = 0; g < NI; g++)
      if (rd_en[g] && int'(rd_addr[g]) < MEMN) rd_data[g] <= mem[g][rd_addr[g]];
  end

  // Output buffer / activity log, sampled away from the rising edge
  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (wr_en[g] && wcnt[g] < LOGN) begin
        waddr[g][wcnt[g]] = int'(wr_addr[g]);
        wdata[g][wcnt[g]] = wr_data[g];
        wcyc[g][wcnt[g]]  = ecnt;
        wcnt[g]++;
      end
      if (done[g]) begin
        done_cnt[g]++;
        done_cyc[g] = ecnt;
      end
      if (busy[g]) busy_last[g] = ecnt;
      if (rd_en[g]) begin
        rd_cnt[g]++;
        if (int'(rd_addr[g]) > rd_max[g]) rd_max[g] = int'(rd_addr[g]);
        if (int'(rd_addr[g]) >= PD[g] * PH[g] * PW[g]) rd_oob[g]++;
      end
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Reference: maximum of window idx computed straight from the map.
  function automatic logic [31:0] ref_val(input int g, input int idx);
    int per, ch, rr, cc;
    logic signed [31:0] m, v;
    per = (PH[g] / 2) * (PW[g] / 2);
    ch  = idx / per;
    rr  = 2 * ((idx % per) / (PW[g] / 2));
    cc  = 2 * ((idx % per) % (PW[g] / 2));
    m   = $signed(mem[g][ch * PH[g] * PW[g] + rr * PW[g] + cc]);
    for (int dy = 0; dy < 2; dy++)
      for (int dx = 0; dx < 2; dx++) begin
        v = $signed(mem[g][ch * PH[g] * PW[g] + (rr + dy) * PW[g] + cc + dx]);
        if (v > m) m = v;
      end
    return m;
  endfunction

  // One full pass; poke>0 re-asserts start for 3 cycles from that cycle.
  task automatic run_pass(input int g, input int poke);
    int n, wb, db, t0, to, rel;
    n  = PD[g] * (PH[g] / 2) * (PW[g] / 2);
    wb = wcnt[g];
    db = done_cnt[g];
    start[g] = 1'b1;
    t0 = ecnt;
    step();
    start[g] = 1'b0;
    to = 0;
    while (done_cnt[g] == db && to < 5 * n + 20) begin
      rel = ecnt - t0;
      start[g] = (poke > 0 && rel >= poke && rel < poke + 3);
      step();
      to++;
    end
    start[g] = 1'b0;
    chk($sformatf("g%0d_done_seen", g), longint'(done_cnt[g] != db), 1);
    repeat (8) step();
    chk($sformatf("g%0d_done_count", g), done_cnt[g] - db, 1);
    chk($sformatf("g%0d_done_cycle", g), done_cyc[g] - t0, 5 * n + 1);
    chk($sformatf("g%0d_busy_last", g), busy_last[g] - t0, 5 * n + 1);
    chk($sformatf("g%0d_busy_idle", g), longint'(busy[g]), 0);
    chk($sformatf("g%0d_nwrites", g), wcnt[g] - wb, n);
    for (int i = 0; i < n && wb + i < LOGN; i++) begin
      chk($sformatf("g%0d_waddr%0d", g, i), waddr[g][wb + i], i);
      chk($sformatf("g%0d_wdata%0d", g, i), longint'($signed(wdata[g][wb + i])),
          longint'($signed(ref_val(g, i))));
      chk($sformatf("g%0d_wcyc%0d", g, i), wcyc[g][wb + i] - t0, 6 + 5 * i);
    end
  endtask

  initial begin
    int exp_a [4];
    int wb, db, rb, t0, to, rel;
    exp_a = '{5, 7, 13, 15};
    rst_n = 1'b0;
    for (int g = 0; g < NI; g++) start[g] = 1'b0;
    repeat (3) step();
    for (int g = 0; g < NI; g++) begin
      chk("rst_busy", longint'(busy[g]), 0);
      chk("rst_done", longint'(done[g]), 0);
      chk("rst_rd_en", longint'(rd_en[g]), 0);
      chk("rst_wr_en", longint'(wr_en[g]), 0);
      chk("rst_addrs", longint'({rd_addr[g], wr_addr[g]}), 0);
      chk("rst_wr_data", longint'(wr_data[g]), 0);
    end
    rst_n = 1'b1;
    step();

    // 4x4 ramp 0..15
    for (int i = 0; i < 16; i++) mem[0][i] = 32'(i);
    wb = wcnt[0];
    run_pass(0, 0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("ramp_const%0d", i), longint'(wdata[0][wb + i]), exp_a[i]);

    // 2x2 all-negative, then a tie
    mem[1][0] = -32'sd8; mem[1][1] = -32'sd3; mem[1][2] = -32'sd5; mem[1][3] = -32'sd9;
    run_pass(1, 0);
    chk("neg_max", longint'($signed(wdata[1][wcnt[1] - 1])), -3);
    for (int i = 0; i < 4; i++) mem[1][i] = 32'd4;
    run_pass(1, 0);
    chk("tie_max", longint'($signed(wdata[1][wcnt[1] - 1])), 4);

    // D=2: channel 1 = channel 0 + 100
    for (int i = 0; i < 16; i++) begin
      mem[2][i]      = 32'($urandom_range(0, 400)) - 32'd200;
      mem[2][16 + i] = mem[2][i] + 32'd100;
    end
    wb = wcnt[2];
    run_pass(2, 0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("ch1_plus100_%0d", i), longint'($signed(wdata[2][wb + 4 + i])),
          longint'($signed(wdata[2][wb + i])) + 100);
    chk("d2_rd_max", rd_max[2], 31);

    // Reset mid-pass in cycle 9
    start[0] = 1'b1;
    t0 = ecnt;
    step();
    start[0] = 1'b0;
    while (ecnt - t0 < 9) step();
    chk("pre_rst_rd_en", longint'(rd_en[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", longint'(busy[0]), 0);
    chk("arst_rd_en", longint'(rd_en[0]), 0);
    chk("arst_rd_addr", longint'(rd_addr[0]), 0);
    chk("arst_wr", longint'({wr_en[0], wr_addr[0]}), 0);
    chk("arst_wr_data", longint'(wr_data[0]), 0);
    db = done_cnt[0];
    wb = wcnt[0];
    rb = rd_cnt[0];
    step();
    rst_n = 1'b1;
    repeat (20) step();
    chk("abort_no_done", done_cnt[0] - db, 0);
    chk("abort_no_wr", wcnt[0] - wb, 0);
    chk("abort_no_rd", rd_cnt[0] - rb, 0);
    run_pass(0, 0);

    // start while busy is ignored
    run_pass(0, 5);

    // start held high: back-to-back passes, second accepted in cycle 22
    wb = wcnt[0];
    db = done_cnt[0];
    start[0] = 1'b1;
    t0 = ecnt;
    to = 0;
    while (done_cnt[0] < db + 2 && to < 80) begin
      step();
      to++;
      rel = ecnt - t0;
      if (rel == 22) chk("held_idle_gap", longint'(busy[0]), 0);
    end
    start[0] = 1'b0;
    chk("held_second_done", done_cyc[0] - t0, 43);
    repeat (15) step();
    chk("held_two_passes", done_cnt[0] - db, 2);
    chk("held_nwrites", wcnt[0] - wb, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("held_waddr%0d", i), waddr[0][wb + i], i % 4);
      chk($sformatf("held_wdata%0d", i), longint'(wdata[0][wb + i]), exp_a[i % 4]);
      chk($sformatf("held_wcyc%0d", i), wcyc[0][wb + i] - t0,
          (i < 4) ? 6 + 5 * i : 28 + 5 * (i - 4));
    end

    // 4x4 random signed data
    for (int i = 0; i < 16; i++) mem[0][i] = $urandom;
    run_pass(0, 0);

    // Default-size map, random data
    for (int i = 0; i < MEMN; i++) mem[3][i] = $urandom;
    run_pass(3, 0);

    for (int g = 0; g < NI; g++) chk($sformatf("g%0d_rd_in_range", g), rd_oob[g], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
